// File: rtl/vedic_div_32.sv
// vedic_div_32: sequential unsigned restoring divider, one quotient bit per clock, valid/ready in and out.
module vedic_div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_qsr, r_div, r_q, r_r;
  logic [CW-1:0] r_cnt;
  logic r_dbz;
  logic [WIDTH:0] w_shift, w_trial;
  logic [WIDTH-1:0] w_rem_n, w_qsr_n;
  logic w_accept, w_last, w_neg;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = r_cnt == '0;
  assign q   = r_q;
  assign r   = r_r;
  assign dbz = r_dbz;
  // Trial subtraction is WIDTH+1 bits wide, so the borrow bit alone decides restore.
  assign w_shift = {r_rem, r_qsr[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};
  assign w_neg   = w_trial[WIDTH];
  assign w_rem_n = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_qsr_n = {r_qsr[WIDTH-2:0], ~w_neg};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_accept ? (b == '0 ? DONE : CALC) : IDLE)
           : r_state == CALC ? (w_last ? DONE : CALC)
           : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rem <= '0;
      r_qsr <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_div <= b;
      if (b == '0) begin
        r_q   <= '1;
        r_r   <= a;
        r_dbz <= 1'b1;
      end else begin
        r_rem <= '0;
        r_qsr <= a;
        r_cnt <= CW'(WIDTH - 1);
        r_dbz <= 1'b0;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_n;
      r_qsr <= w_qsr_n;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_q <= w_qsr_n;
        r_r <= w_rem_n;
      end
    end
endmodule

// File: tb/tb_vedic_div_32.sv
// tb_vedic_div_32: directed and random checks of the restoring divider with immediate assertions.
module tb_vedic_div_32;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic in_ready, out_valid, dbz;
  logic [31:0] q, r;
  int n_cmp = 0, n_err = 0, lat;
  vedic_div_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .dbz(dbz)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [31:0] av, input logic [31:0] bv);
    int n = 0;
    a_i = av;
    b_i = bv;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_res(input bit noise);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a_i = $urandom;
        b_i = $urandom;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask
  task automatic check_res(input string tag, input logic [31:0] eq, input logic [31:0] er,
                           input logic ed, input int elat);
    chk({tag, " lat"}, 64'(lat), 64'(elat));
    chk({tag, " q"}, {32'd0, q}, {32'd0, eq});
    chk({tag, " r"}, {32'd0, r}, {32'd0, er});
    chk({tag, " dbz"}, {63'd0, dbz}, {63'd0, ed});
  endtask
  task automatic hs(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, " hs out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, " hs in_ready"}, {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask
  task automatic div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eq, input logic [31:0] er, input logic ed);
    start(av, bv);
    wait_res(1'b0);
    check_res(tag, eq, er, ed, ed ? 0 : 32);
    hs(tag);
  endtask
  initial begin
    #3;
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst q", {32'd0, q}, 64'd0);
    chk("rst r", {32'd0, r}, 64'd0);
    chk("rst dbz", {63'd0, dbz}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    div("144/12", 32'd144, 32'd12, 32'd12, 32'd0, 1'b0);
    div("195/13", 32'd195, 32'd13, 32'd15, 32'd0, 1'b0);
    div("4200/21", 32'd4200, 32'd21, 32'd200, 32'd0, 1'b0);
    div("1728/48", 32'd1728, 32'd48, 32'd36, 32'd0, 1'b0);
    div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    div("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    div("10/3", 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
    out_ready = 1'b0;
    start(32'd200, 32'd21);
    wait_res(1'b0);
    check_res("bp 200/21", 32'd9, 32'd11, 1'b0, 32);
    for (int i = 0; i < 20; i++) begin
      in_valid = i == 5;
      a_i = i == 5 ? 32'd7 : a_i;
      b_i = i == 5 ? 32'd7 : b_i;
      tick();
      chk("bp q", {32'd0, q}, 64'd9);
      chk("bp r", {32'd0, r}, 64'd11);
      chk("bp out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    hs("bp");
    chk("bp hold q", {32'd0, q}, 64'd9);
    chk("bp hold r", {32'd0, r}, 64'd11);
    start(32'd1000, 32'd3);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst q", {32'd0, q}, 64'd0);
    chk("arst r", {32'd0, r}, 64'd0);
    chk("arst dbz", {63'd0, dbz}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    div("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] av, bv, eq, er;
      int sel;
      av = $urandom;
      sel = $urandom_range(0, 9);
      bv = sel == 0 ? 32'd0
         : sel <= 2 ? 32'($urandom_range(1, 15))
         : sel <= 4 ? av + 32'($urandom_range(1, 1000))
         : sel == 5 ? av >> $urandom_range(0, 31)
         : $urandom;
      eq = bv == 0 ? 32'hFFFF_FFFF : av / bv;
      er = bv == 0 ? av : av % bv;
      repeat ($urandom_range(0, 3)) tick();
      start(av, bv);
      wait_res(1'b1);
      check_res("rnd", eq, er, bv == 0, bv == 0 ? 0 : 32);
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("rnd stall out_valid", {63'd0, out_valid}, 64'd1);
      end
      hs("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
